// File: rtl/atm_txn_engine.sv
// Multi-account ATM transaction engine.
// Each request goes through authentication and execution in fixed latency.
module atm_txn_engine #(
  parameter int NUM_ACC = 16,
  parameter int ACC_W = 4,
  parameter int PIN_W = 16,
  parameter int BAL_W = 32,
  parameter int MAX_TRIES = 3,
  parameter int WD_LIMIT = 1000,
  parameter int INIT_BAL = 500,
  parameter logic [PIN_W-1:0] INIT_PIN = 16'h1234
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [ACC_W-1:0] acc_num_i,
  input  logic [PIN_W-1:0] pin_i,
  input  logic [PIN_W-1:0] new_pin_i,
  input  logic [BAL_W-1:0] amount_i,
  output logic             done_o,
  output logic             success_o,
  output logic [2:0]       err_o,
  output logic [BAL_W-1:0] balance_o,
  output logic             locked_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AUTH = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_WD  = 3'd1;
  localparam logic [2:0] OP_DEP = 3'd2;
  localparam logic [2:0] OP_PIN = 3'd3;

  localparam logic [2:0] E_OK     = 3'd0;
  localparam logic [2:0] E_BADACC = 3'd1;
  localparam logic [2:0] E_LOCKED = 3'd2;
  localparam logic [2:0] E_BADPIN = 3'd3;
  localparam logic [2:0] E_FUNDS  = 3'd4;
  localparam logic [2:0] E_LIMIT  = 3'd5;
  localparam logic [2:0] E_OVFL   = 3'd6;
  localparam logic [2:0] E_BADOP  = 3'd7;

  localparam int FW = $clog2(MAX_TRIES + 1);

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [PIN_W-1:0] npin_q;
  logic [BAL_W-1:0] amt_q;
  logic [2:0]       aerr_q;
  logic             lk_q;

  logic [BAL_W-1:0] bal_mem_q [NUM_ACC];
  logic [PIN_W-1:0] pin_mem_q [NUM_ACC];
  logic [FW-1:0]    fail_q    [NUM_ACC];
  logic             lock_q    [NUM_ACC];

  logic             succ_q;
  logic [2:0]       err_q;
  logic [BAL_W-1:0] balo_q;
  logic             lko_q;

  logic             acc_ok;
  logic [ACC_W-1:0] idx;
  logic [BAL_W-1:0] cur_bal;
  logic [FW-1:0]    fail_nx;
  logic [BAL_W:0]   dep_sum;
  logic [2:0]       ex_err;
  logic [BAL_W-1:0] ex_bal;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_d = AUTH;
      end
      AUTH: state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Account lookup and execution result for the latched request
  always_comb begin
    acc_ok  = (int'(acc_q) < NUM_ACC);
    idx     = acc_ok ? acc_q : '0;
    cur_bal = bal_mem_q[idx];
    fail_nx = fail_q[idx] + FW'(1);
    dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};
    ex_err  = aerr_q;
    ex_bal  = acc_ok ? cur_bal : '0;
    if (aerr_q == E_OK) begin
      if (op_q == OP_WD) begin
        if (amt_q > BAL_W'(WD_LIMIT))  ex_err = E_LIMIT;
        else if (amt_q > cur_bal)      ex_err = E_FUNDS;
        else                           ex_bal = cur_bal - amt_q;
      end else if (op_q == OP_DEP) begin
        if (dep_sum[BAL_W]) ex_err = E_OVFL;
        else                ex_bal = dep_sum[BAL_W-1:0];
      end
    end
  end

  // Request latch, account arrays and registered result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q   <= '0;
      acc_q  <= '0;
      pin_q  <= '0;
      npin_q <= '0;
      amt_q  <= '0;
      aerr_q <= E_OK;
      lk_q   <= 1'b0;
      succ_q <= 1'b0;
      err_q  <= E_OK;
      balo_q <= '0;
      lko_q  <= 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
        bal_mem_q[i] <= BAL_W'(INIT_BAL);
        pin_mem_q[i] <= INIT_PIN;
        fail_q[i]    <= '0;
        lock_q[i]    <= 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q   <= op_i;
            acc_q  <= acc_num_i;
            pin_q  <= pin_i;
            npin_q <= new_pin_i;
            amt_q  <= amount_i;
          end
        end
        AUTH: begin
          if (!acc_ok) begin
            aerr_q <= E_BADACC;
            lk_q   <= 1'b0;
          end else if (lock_q[idx]) begin
            aerr_q <= E_LOCKED;
            lk_q   <= 1'b1;
          end else if (pin_q != pin_mem_q[idx]) begin
            aerr_q      <= E_BADPIN;
            fail_q[idx] <= fail_nx;
            if (int'(fail_nx) >= MAX_TRIES) begin
              lock_q[idx] <= 1'b1;
              lk_q        <= 1'b1;
            end else begin
              lk_q <= 1'b0;
            end
          end else begin
            fail_q[idx] <= '0;
            lk_q        <= 1'b0;
            aerr_q      <= (op_q > OP_PIN) ? E_BADOP : E_OK;
          end
        end
        EXEC: begin
          err_q  <= ex_err;
          succ_q <= (ex_err == E_OK);
          balo_q <= ex_bal;
          lko_q  <= lk_q;
          if (ex_err == E_OK) begin
            if (op_q == OP_WD || op_q == OP_DEP)
              bal_mem_q[idx] <= ex_bal;
            else if (op_q == OP_PIN)
              pin_mem_q[idx] <= npin_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign success_o = succ_q;
  assign err_o     = err_q;
  assign balance_o = balo_q;
  assign locked_o  = lko_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_atm_txn_engine.sv
// Bench for atm_txn_engine: directed scenarios plus random traffic,
// scored against a behavioural account model through a result queue.
module tb_atm_txn_engine;

  localparam int NA = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [2:0]  op;
  logic [3:0]  acc;
  logic [15:0] pin;
  logic [15:0] npin;
  logic [31:0] amt;
  logic        done;
  logic        success;
  logic [2:0]  err;
  logic [31:0] balance;
  logic        locked;
  logic [1:0]  state;

  atm_txn_engine #(.NUM_ACC(NA)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready),
    .op_i(op), .acc_num_i(acc), .pin_i(pin), .new_pin_i(npin),
    .amount_i(amt), .done_o(done), .success_o(success), .err_o(err),
    .balance_o(balance), .locked_o(locked), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  err;
    logic [31:0] bal;
    logic        lk;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;

  longint      m_bal [16];
  logic [15:0] m_pin [16];
  int          m_fail[16];
  bit          m_lk  [16];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_bal[i] = 500;
      m_pin[i] = 16'h1234;
      m_fail[i] = 0;
      m_lk[i] = 0;
    end
  endfunction

  function automatic exp_t model(input logic [2:0] o, input int a,
                                 input logic [15:0] p, input logic [15:0] np,
                                 input longint am);
    exp_t e;
    e.err = 0; e.bal = 0; e.lk = 0;
    if (a >= NA) begin
      e.err = 1;
      return e;
    end
    e.bal = m_bal[a][31:0];
    if (m_lk[a]) begin
      e.err = 2; e.lk = 1;
      return e;
    end
    if (p != m_pin[a]) begin
      m_fail[a]++;
      if (m_fail[a] >= 3) m_lk[a] = 1;
      e.err = 3; e.lk = m_lk[a];
      return e;
    end
    m_fail[a] = 0;
    case (o)
      0: ;
      1: if (am > 1000) e.err = 5;
         else if (am > m_bal[a]) e.err = 4;
         else m_bal[a] = m_bal[a] - am;
      2: if (m_bal[a] + am > 64'hFFFF_FFFF) e.err = 6;
         else m_bal[a] = m_bal[a] + am;
      3: m_pin[a] = np;
      default: e.err = 7;
    endcase
    e.bal = m_bal[a][31:0];
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        e = q.pop_front();
        check("sb_err", err, e.err);
        check("sb_success", success, (e.err == 0));
        check("sb_balance", balance, e.bal);
        check("sb_locked", locked, e.lk);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [3:0] a,
                       input logic [15:0] p, input logic [15:0] np,
                       input logic [31:0] am);
    int w = 0;
    int lat = 0;
    @(negedge clk);
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    op = o; acc = a; pin = p; npin = np; amt = am;
    start = 1'b1;
    q.push_back(model(o, int'(a), p, np, longint'(am)));
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); acc = 4'($urandom);
    pin = 16'($urandom); npin = 16'($urandom); amt = $urandom;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    check("latency", lat, 3);
  endtask

  function automatic logic [31:0] rnd_amt();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 600);
      1: return $urandom_range(995, 1005);
      2: return $urandom;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    int d0;
    logic [3:0] ra;
    logic [15:0] rp;
    rst = 1'b1; start = 1'b0;
    op = 0; acc = 0; pin = 0; npin = 0; amt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_state", state, 0);
    check("rst_err", err, 0);
    check("rst_balance", balance, 0);
    check("rst_success", success, 0);
    check("rst_locked", locked, 0);

    issue(0, 2, 16'h1234, 0, 0);
    check("t1_balance", balance, 500);
    issue(1, 2, 16'h1234, 0, 200);
    check("t2_wd200", balance, 300);
    issue(1, 2, 16'h1234, 0, 301);
    check("t2_nofunds", err, 4);
    issue(1, 2, 16'h1234, 0, 1001);
    check("t2_limit", err, 5);
    issue(1, 2, 16'h1234, 0, 300);
    check("t2_to_zero", balance, 0);
    issue(2, 2, 16'h1234, 0, 0);
    check("t2_dep0", success, 1);

    for (int i = 0; i < 3; i++) issue(0, 5, 16'h0000, 0, 0);
    check("t3_lock3", locked, 1);
    issue(0, 5, 16'h1234, 0, 0);
    check("t3_locked_err", err, 2);

    issue(2, 7, 16'h1234, 0, 32'hFFFF_FE0C);
    check("t4_ovfl", err, 6);
    issue(2, 7, 16'h1234, 0, 32'hFFFF_FE0B);
    check("t4_max", balance, 32'hFFFF_FFFF);

    issue(3, 1, 16'h1234, 16'hBEEF, 0);
    issue(0, 1, 16'h1234, 0, 0);
    check("t5_oldpin", err, 3);
    issue(0, 1, 16'hBEEF, 0, 0);
    check("t5_newpin", success, 1);

    issue(0, 4'(NA), 16'h1234, 0, 0);
    check("t6_badacc", err, 1);
    issue(0, 15, 16'h1234, 0, 0);
    check("t6_badacc15", balance, 0);
    issue(6, 3, 16'h1234, 0, 0);
    check("t6_badop", err, 7);

    // reset during EXEC of a withdraw
    @(negedge clk);
    op = 1; acc = 3; pin = 16'h1234; amt = 100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 check("t6_in_exec", state, 2);
    rst = 1'b1;
    d0 = n_done;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    check("t6_no_done", n_done, d0);
    issue(0, 3, 16'h1234, 0, 0);
    check("t6_bal_after_rst", balance, 500);

    for (int i = 0; i < 150; i++) begin
      ra = 4'($urandom_range(0, 15));
      rp = ($urandom_range(0, 9) < 8) ? m_pin[ra] : 16'($urandom);
      issue(3'($urandom_range(0, 9) < 9 ? $urandom_range(0, 3) : $urandom_range(4, 7)),
            ra, rp, 16'($urandom), rnd_amt());
    end

    repeat (4) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
